// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps a one-bit shifter once per clock to perform
// pass/LSL/LSR/ASR shifts of 0..15 positions, signalling completion with a done pulse.

module shifter (
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);

  // One-position shift selected by the op encoding
  always_comb begin
    sout = in;
    case (shift)
      2'b01:   sout = {in[14:0], 1'b0};
      2'b10:   sout = {1'b0, in[15:1]};
      2'b11:   sout = {in[15], in[15:1]};
      default: sout = in;
    endcase
  end

endmodule

module shift_sequencer #(
  parameter int AMT_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] din,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [AMT_W-1:0]  steps_left
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              next_s;
  logic [DATA_W-1:0]   acc_r;
  logic [1:0]          op_r;
  logic [AMT_W-1:0]    steps_r;
  logic [DATA_W-1:0]   result_r;
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   sout_s;
  logic                accept_s;
  logic                last_step_s;

  shifter u_shifter (
    .in    (acc_r),
    .shift (op_r),
    .sout  (sout_s)
  );

  // abort wins over start, so a simultaneous pair leaves the block idle
  assign accept_s    = (state_r == ST_IDLE) && start && !abort;
  assign last_step_s = (steps_r == AMT_ONE);

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if ((amount == AMT_ZERO) || (op == 2'b00)) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_SHIFT;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          next_s = ST_IDLE;
        end else if (last_step_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_SHIFT;
        end
      end
      ST_DONE: next_s  = ST_IDLE;
      default: next_s  = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; busy/done derive from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      acc_r    <= {DATA_W{1'b0}};
      op_r     <= 2'b00;
      steps_r  <= AMT_ZERO;
      result_r <= {DATA_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != ST_IDLE);
      done_r  <= (next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_r   <= din;
            op_r    <= op;
            steps_r <= amount;
            if (next_s == ST_DONE) begin
              result_r <= din;
            end
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            steps_r <= AMT_ZERO;
          end else begin
            acc_r   <= sout_s;
            steps_r <= steps_r - AMT_ONE;
            if (last_step_s) begin
              result_r <= sout_s;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            steps_r <= AMT_ZERO;
          end
        end
        default: steps_r <= AMT_ZERO;
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign steps_left = steps_r;

endmodule
